soc_event_tx: RTL

SoC-side transmitter for the cluster peripheral event channel (valid/ready/data), feeding the event unit's SoC event input. It collects single-cycle event pulses from up to NB_SRC SoC peripherals and latches them as pending. A round-robin arbiter picks one pending source per cycle and queues its event ID in a small FIFO. The FIFO head drives the channel with a stable valid/ready handshake.

---
 rtl/soc_event_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/soc_event_tx.sv
// SoC-side event transmitter: latches event pulses as pending, picks one per cycle
// round-robin, queues its ID and drives a valid/ready channel. Macro SOC_EVT_TX_LOST_CNT_EN adds a lost-event counter.
module soc_event_tx #(
    parameter int unsigned NB_SRC     = 16,
    parameter int unsigned EVNT_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_BASE    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NB_SRC-1:0]     evt_i,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [EVNT_WIDTH-1:0] evt_data_o,
    output logic [NB_SRC-1:0]     pending_o,
    output logic                  overflow_o,
    input  logic                  clr_overflow_i,
    output logic [7:0]            lost_cnt_o
);

    localparam int unsigned SW = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [NB_SRC-1:0]     pending_q;
    logic [NB_SRC-1:0]     pending_d;
    logic [NB_SRC-1:0]     grant;
    logic [NB_SRC-1:0]     lost;
    logic [SW-1:0]         last_grant_q;
    logic [SW-1:0]         grant_idx;
    logic                  grant_vld;
    logic [EVNT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  overflow_q;

    // Full is taken from the registered count only: no grant while full, no bypass.
    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = (count != '0) && evt_ready_i;
    assign push = grant_vld;

    // Round-robin search starting one past the last granted source.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        grant     = '0;
        if (!full) begin
            for (int unsigned i = 1; i <= NB_SRC; i++) begin
                idx = (32'(last_grant_q) + i) % NB_SRC;
                if (!grant_vld && pending_q[SW'(idx)]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(idx);
                end
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A pulse on a granted source re-arms its pending bit instead of being lost.
    assign pending_d = (pending_q & ~grant) | evt_i;
    assign lost      = evt_i & pending_q & ~grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q    <= '0;
            last_grant_q <= SW'(NB_SRC - 1);
        end else begin
            pending_q <= pending_d;
            if (grant_vld) begin
                last_grant_q <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[PW'(i)] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= EVNT_WIDTH'(ID_BASE + 32'(grant_idx));
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Clear wins over a same-cycle loss.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (clr_overflow_i) begin
            overflow_q <= 1'b0;
        end else if (|lost) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef SOC_EVT_TX_LOST_CNT_EN
    logic [7:0] lost_cnt_q;

    // One increment per cycle with any loss, saturating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lost_cnt_q <= '0;
        end else if (clr_overflow_i) begin
            lost_cnt_q <= '0;
        end else if ((|lost) && (lost_cnt_q != 8'hFF)) begin
            lost_cnt_q <= lost_cnt_q + 8'd1;
        end
    end

    assign lost_cnt_o = lost_cnt_q;
`else
    assign lost_cnt_o = '0;
`endif

    assign evt_valid_o = (count != '0);
    assign evt_data_o  = mem[rd_ptr];
    assign pending_o   = pending_q;
    assign overflow_o  = overflow_q;

endmodule
